// File: rtl/instr_loader.sv
// instr_loader: byte-serial loader packing a 0xFE..0xFF framed stream into 32-bit instruction-memory writes.
// Define INSTR_LOADER_RELOAD_EN to let a 0xFE byte in DONE start a fresh load.
module instr_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              reset,
    input  logic [7:0]        instr_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              cpu_hold_o,
    output logic              done_o,
    output logic [ADDR_W:0]   word_count_o,
    output logic              overflow_o
);
    localparam logic [ADDR_W:0]   L_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] L_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [7:0]        L_START = 8'hFE;
    localparam logic [7:0]        L_END   = 8'hFF;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t              r_state, w_state_n;
    logic [3:0]          r_idx;
    logic [23:0]         r_shift;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_waddr;
    logic [ADDR_W:0]     r_count;
    logic [31:0]         r_wdata;
    logic                r_we, r_hold, r_done, r_ovf;
    logic                w_start, w_data, w_word, w_wr;

    // Markers only count at byte index 0; later bytes of a word are always data.
    always_comb begin
        w_state_n = r_state;
        w_start   = 1'b0;
        w_data    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_n = (instr_i == L_START) ? S_LOAD : S_IDLE;
                w_start   = (instr_i == L_START);
            end
            S_LOAD: begin
                w_state_n = (r_idx == 4'd0 && instr_i == L_END) ? S_DONE : S_LOAD;
                w_start   = (r_idx == 4'd0 && instr_i == L_START);
                w_data    = (r_idx != 4'd0) || (instr_i != L_START && instr_i != L_END);
            end
            S_DONE: begin
`ifdef INSTR_LOADER_RELOAD_EN
                w_state_n = (instr_i == L_START) ? S_LOAD : S_DONE;
                w_start   = (instr_i == L_START);
`else
                w_state_n = S_DONE;
`endif
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    assign w_word = w_data && (r_idx == 4'd3);
    assign w_wr   = w_word && (r_count < L_DEPTH);

    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= 4'd0;
            r_shift <= 24'd0;
            r_addr  <= '0;
            r_waddr <= '0;
            r_count <= '0;
            r_wdata <= 32'd0;
            r_we    <= 1'b0;
            r_hold  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_hold  <= (w_state_n == S_LOAD);
            r_done  <= (w_state_n == S_DONE);
            r_we    <= w_wr;
            if (w_start) begin
                r_idx   <= 4'd0;
                r_shift <= 24'd0;
                r_addr  <= '0;
                r_count <= '0;
                r_ovf   <= 1'b0;
            end else if (w_data) begin
                r_idx   <= w_word ? 4'd0 : 4'(r_idx + 4'd1);
                r_shift <= {instr_i, r_shift[23:8]};
            end
            if (w_wr) begin
                r_wdata <= {instr_i, r_shift};
                r_waddr <= r_addr;
                r_addr  <= (r_addr == L_LAST) ? r_addr : ADDR_W'(r_addr + 1'b1);
                r_count <= (ADDR_W+1)'(r_count + 1'b1);
            end
            if (w_word && !w_wr) r_ovf <= 1'b1;
        end
    end

    assign imem_we_o    = r_we;
    assign imem_addr_o  = r_waddr;
    assign imem_wdata_o = r_wdata;
    assign cpu_hold_o   = r_hold;
    assign done_o       = r_done;
    assign word_count_o = r_count;
    assign overflow_o   = r_ovf;
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed scenarios plus a random byte stream checked against a queue-based loader model.
module tb_instr_loader;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk_i = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    instr_i = 8'h00;
    logic          imem_we_o;
    logic [AW-1:0] imem_addr_o;
    logic [31:0]   imem_wdata_o;
    logic          cpu_hold_o;
    logic          done_o;
    logic [AW:0]   word_count_o;
    logic          overflow_o;

    int checks = 0;
    int errors = 0;

    instr_loader #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk_i        (clk_i),
        .reset        (reset),
        .instr_i      (instr_i),
        .imem_we_o    (imem_we_o),
        .imem_addr_o  (imem_addr_o),
        .imem_wdata_o (imem_wdata_o),
        .cpu_hold_o   (cpu_hold_o),
        .done_o       (done_o),
        .word_count_o (word_count_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    logic [AW+31:0] dut_wq[$];
    always @(posedge clk_i) begin
        #1;
        if (imem_we_o === 1'b1) dut_wq.push_back({imem_addr_o, imem_wdata_o});
    end

    // Reference model: 0 idle, 1 loading, 2 done; partial word kept as a byte list.
    int            m_state = 0;
    byte unsigned  m_part[$];
    int            m_count = 0;
    bit            m_ovf = 0;
    bit            m_we = 0;
    logic [AW-1:0] m_addr = '0;
    logic [31:0]   m_data = '0;

    task automatic model_clear();
        m_count = 0;
        m_ovf   = 0;
        m_part.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        m_we = 0;
        if (m_state == 0) begin
            if (b == 8'hFE) begin m_state = 1; model_clear(); end
        end else if (m_state == 1) begin
            if (m_part.size() == 0 && b == 8'hFF) m_state = 2;
            else if (m_part.size() == 0 && b == 8'hFE) model_clear();
            else begin
                m_part.push_back(b);
                if (m_part.size() == 4) begin
                    if (m_count < DEPTH) begin
                        m_we   = 1;
                        m_addr = AW'(m_count);
                        m_data = {m_part[3], m_part[2], m_part[1], m_part[0]};
                        m_count++;
                    end else m_ovf = 1;
                    m_part.delete();
                end
            end
        end else begin
`ifdef INSTR_LOADER_RELOAD_EN
            if (b == 8'hFE) begin m_state = 1; model_clear(); end
`endif
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk_i);
        instr_i = b;
        @(posedge clk_i);
        model_byte(b);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset   = 1'b1;
        instr_i = 8'hFE;
        @(posedge clk_i);
        m_state = 0;
        model_clear();
        m_we = 0; m_addr = '0; m_data = '0;
        #2;
        @(negedge clk_i);
        reset   = 1'b0;
        instr_i = 8'h00;
        @(posedge clk_i);
        model_byte(8'h00);
        #2;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({imem_we_o, imem_addr_o, imem_wdata_o, cpu_hold_o, done_o, word_count_o, overflow_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs we=%b addr=%0d data=%h hold=%b done=%b cnt=%0d ovf=%b required all zero",
                     imem_we_o, imem_addr_o, imem_wdata_o, cpu_hold_o, done_o, word_count_o, overflow_o);
        end
    endtask

    task automatic test_single();
        logic [7:0] s[6] = '{8'hFE, 8'h13, 8'h00, 8'h00, 8'h00, 8'hFF};
        do_reset();
        dut_wq.delete();
        foreach (s[i]) send(s[i]);
        checks++;
        if (dut_wq.size() != 1) begin errors++; $display("FAIL single_nwrites got %0d required 1", dut_wq.size()); end
        checks++;
        if (dut_wq.size() > 0 && dut_wq[0] !== {6'd0, 32'h00000013}) begin
            errors++; $display("FAIL single_write got %h required %h", dut_wq[0], {6'd0, 32'h00000013});
        end
        checks++;
        if ({cpu_hold_o, done_o, word_count_o, overflow_o} !== {1'b0, 1'b1, 7'd1, 1'b0}) begin
            errors++; $display("FAIL single_status hold=%b done=%b cnt=%0d ovf=%b required 0 1 1 0",
                               cpu_hold_o, done_o, word_count_o, overflow_o);
        end
    endtask

    task automatic test_noise();
        logic [7:0] s[4] = '{8'h00, 8'h13, 8'hFF, 8'h00};
        do_reset();
        dut_wq.delete();
        foreach (s[i]) send(s[i]);
        checks++;
        if (dut_wq.size() != 0) begin errors++; $display("FAIL noise_nwrites got %0d required 0", dut_wq.size()); end
        checks++;
        if ({cpu_hold_o, done_o, word_count_o} !== '0) begin
            errors++; $display("FAIL noise_status hold=%b done=%b cnt=%0d required 0 0 0", cpu_hold_o, done_o, word_count_o);
        end
    endtask

    task automatic test_full(input int nw);
        do_reset();
        dut_wq.delete();
        send(8'hFE);
        for (int k = 0; k < nw; k++) for (int j = 0; j < 4; j++) send(8'(k));
        send(8'hFF);
        checks++;
        if (dut_wq.size() != DEPTH) begin errors++; $display("FAIL full_nwrites words=%0d got %0d required %0d", nw, dut_wq.size(), DEPTH); end
        for (int k = 0; k < dut_wq.size() && k < DEPTH; k++) begin
            logic [7:0] kb;
            kb = 8'(k);
            checks++;
            if (dut_wq[k] !== {AW'(k), {4{kb}}}) begin
                errors++; $display("FAIL full_write[%0d] got %h required %h", k, dut_wq[k], {AW'(k), {4{kb}}});
            end
        end
        checks++;
        if ({done_o, word_count_o, overflow_o} !== {1'b1, 7'd64, nw > DEPTH}) begin
            errors++; $display("FAIL full_status words=%0d done=%b cnt=%0d ovf=%b required 1 64 %0d",
                               nw, done_o, word_count_o, overflow_o, nw > DEPTH);
        end
    endtask

    task automatic test_embedded();
        logic [7:0] s[6] = '{8'hFE, 8'h93, 8'hFF, 8'hFE, 8'h0F, 8'hFF};
        do_reset();
        dut_wq.delete();
        foreach (s[i]) send(s[i]);
        checks++;
        if (dut_wq.size() != 1 || dut_wq[0] !== {6'd0, 32'h0FFEFF93}) begin
            errors++; $display("FAIL embedded_write n=%0d first=%h required 1 write of %h",
                               dut_wq.size(), dut_wq.size() ? dut_wq[0] : '0, {6'd0, 32'h0FFEFF93});
        end
        checks++;
        if ({cpu_hold_o, done_o} !== 2'b01) begin errors++; $display("FAIL embedded_done hold=%b done=%b required 0 1", cpu_hold_o, done_o); end
    endtask

    task automatic test_midreset();
        logic [7:0] s[5] = '{8'hFE, 8'h13, 8'h00, 8'h00, 8'h00};
        do_reset();
        dut_wq.delete();
        send(8'hFE); send(8'hAA); send(8'hBB);
        do_reset();
        checks++;
        if (dut_wq.size() != 0 || {imem_we_o, imem_addr_o, imem_wdata_o, cpu_hold_o, done_o, word_count_o, overflow_o} !== '0) begin
            errors++; $display("FAIL midreset_clear writes=%0d hold=%b cnt=%0d data=%h required no writes and zeros",
                               dut_wq.size(), cpu_hold_o, word_count_o, imem_wdata_o);
        end
        foreach (s[i]) send(s[i]);
        checks++;
        if (dut_wq.size() != 1 || dut_wq[0] !== {6'd0, 32'h00000013}) begin
            errors++; $display("FAIL midreset_write n=%0d first=%h required 1 write of %h",
                               dut_wq.size(), dut_wq.size() ? dut_wq[0] : '0, {6'd0, 32'h00000013});
        end
    endtask

    task automatic test_reload();
        logic [7:0] s[6] = '{8'hFE, 8'h13, 8'h00, 8'h00, 8'h00, 8'hFF};
        do_reset();
        foreach (s[i]) send(s[i]);
        dut_wq.delete();
        send(8'hFE);
        checks++;
`ifdef INSTR_LOADER_RELOAD_EN
        if ({cpu_hold_o, done_o, word_count_o} !== {1'b1, 1'b0, 7'd0}) begin
            errors++; $display("FAIL reload_fe hold=%b done=%b cnt=%0d required 1 0 0", cpu_hold_o, done_o, word_count_o);
        end
`else
        if ({cpu_hold_o, done_o, word_count_o} !== {1'b0, 1'b1, 7'd1}) begin
            errors++; $display("FAIL reload_fe hold=%b done=%b cnt=%0d required 0 1 1", cpu_hold_o, done_o, word_count_o);
        end
`endif
        send(8'h33); send(8'h00); send(8'h00); send(8'h00);
        checks++;
`ifdef INSTR_LOADER_RELOAD_EN
        if (dut_wq.size() != 1 || dut_wq[0] !== {6'd0, 32'h00000033}) begin
            errors++; $display("FAIL reload_write n=%0d required 1 write of %h", dut_wq.size(), {6'd0, 32'h00000033});
        end
`else
        if (dut_wq.size() != 0 || done_o !== 1'b1) begin
            errors++; $display("FAIL reload_ignored n=%0d done=%b required 0 writes done 1", dut_wq.size(), done_o);
        end
`endif
    endtask

    task automatic test_random();
        logic [7:0] b;
        int r;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            b = (r < 8) ? 8'hFE : (r < 13) ? 8'hFF : 8'($urandom);
            if (r == 99) do_reset();
            else send(b);
            checks++;
            if ({imem_we_o, imem_addr_o, imem_wdata_o, cpu_hold_o, done_o, word_count_o, overflow_o} !==
                {m_we, m_addr, m_data, m_state == 1, m_state == 2, 7'(m_count), m_ovf}) begin
                errors++;
                $display("FAIL random[%0d] byte=%h got we=%b addr=%0d data=%h hold=%b done=%b cnt=%0d ovf=%b required we=%b addr=%0d data=%h hold=%b done=%b cnt=%0d ovf=%b",
                         i, b, imem_we_o, imem_addr_o, imem_wdata_o, cpu_hold_o, done_o, word_count_o, overflow_o,
                         m_we, m_addr, m_data, m_state == 1, m_state == 2, m_count, m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_noise();
        test_full(64);
        test_full(65);
        test_embedded();
        test_midreset();
        test_reload();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_loader.md
# instr_loader

Byte-serial instruction loader between the external `instr_i` byte port and the CPU's instruction memory. It watches the incoming byte stream for a start marker and packs the following bytes into 32-bit RV32I words. Each word is written to instruction memory at consecutive word addresses. The CPU core is held in stall until an end marker closes the program.

## Interface
Parameters:
- `DEPTH`, 64: instruction memory depth in words.
- `ADDR_W`, 6: word-address width; must satisfy 2^ADDR_W ≥ DEPTH.

Ports:
- `clk_i`, input, 1: clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `instr_i`, input, 8: stream byte, sampled every rising edge; one byte per cycle, no valid qualifier.
- `imem_we_o`, output, 1: one-cycle write strobe to instruction memory.
- `imem_addr_o`, output, ADDR_W: word address of the write.
- `imem_wdata_o`, output, 32: assembled instruction word.
- `cpu_hold_o`, output, 1: high while state is LOAD; the core stalls on it.
- `done_o`, output, 1: high once the program is loaded (state DONE).
- `word_count_o`, output, ADDR_W+1: number of words written so far.
- `overflow_o`, output, 1: sticky flag; a word arrived after DEPTH words were already written.

## Operation
Markers and byte order:
- Start marker is 0xFE; end marker is 0xFF.
- Markers are recognised only at byte index 0 of a word.
- Byte order is little-endian: the first byte of a word is bits [7:0], the fourth is bits [31:24].
- A byte-0 value of 0xFE or 0xFF can never collide with program data, because RV32I has no opcode 0x7E or 0x7F.

States and transitions:
- IDLE (after reset): every byte except 0xFE is ignored. 0xFE → LOAD, with byte index 0, write address 0 and word_count 0.
- LOAD, byte index 0:
  - 0xFF → DONE.
  - 0xFE → restart: address 0, word_count 0, overflow cleared.
  - Any other value is taken as data byte 0.
- LOAD, byte index 1-3: every value is data, including 0x00, 0xFE and 0xFF.
- LOAD, fourth byte: the word is complete.
  - If word_count < DEPTH: write the word at the current address, then increment the address and word_count.
  - Otherwise: no write, and overflow_o is set.
- DONE: all bytes are ignored until reset (see Configuration).

Field and counter rules:
- Partial-word bytes are held in a 24-bit shift register; the 4-bit byte index wraps 3 → 0.
- word_count saturates at DEPTH.
- The address register holds its final value and does not wrap.

Reset values:
- `imem_we_o` 0, `imem_addr_o` 0, `imem_wdata_o` 0.
- `cpu_hold_o` 0, `done_o` 0, `word_count_o` 0, `overflow_o` 0.
- State IDLE, byte index 0, shift register 0.
- Instruction memory contents are not touched by reset.

## Timing
- All outputs are registered.
- When the fourth byte is sampled at edge N:
  - `imem_we_o`, `imem_addr_o` and `imem_wdata_o` are valid from edge N until edge N+1.
  - `imem_we_o` is low again after edge N+1 unless another write follows.
  - `word_count_o` shows the incremented count after edge N.
- `cpu_hold_o` rises on the edge that samples 0xFE in IDLE.
- `cpu_hold_o` falls, and `done_o` rises, on the edge that samples 0xFF at byte index 0.
- Minimum spacing between writes is 4 cycles.
- Reset mid-word or mid-write:
  - The partial word is discarded and no write is issued.
  - After that edge all outputs hold their reset values.
- Simultaneous reset and a marker byte: reset wins.
- 0xFF arriving at byte index 1-3 is stored as data and does not end loading.

## Configuration
- `INSTR_LOADER_RELOAD_EN` defined: in DONE, a 0xFE byte returns the block to LOAD.
  - Address and word_count restart at 0; overflow_o and done_o clear.
  - cpu_hold_o rises on the same edge.
- Not defined: DONE is terminal until reset; 0xFE in DONE is ignored.

## Test plan
1. Single word: reset, then stream FE, 13, 00, 00, 00, FF.
   - Exactly one `imem_we_o` pulse, with addr 0 and data 0x00000013.
   - `done_o` = 1 and `cpu_hold_o` = 0 after the FF edge; `word_count_o` = 1.
2. Pre-start noise: stream 00, 13, FF, 00 with no FE.
   - No writes; `done_o` = 0, `cpu_hold_o` = 0, `word_count_o` = 0.
3. Full load: FE, 256 bytes where word k = {k, k, k, k}, then FF.
   - 64 writes with addr 0..63 and data 0x00000000..0x3F3F3F3F.
   - `word_count_o` = 64 and `overflow_o` = 0.
   - Repeat with 260 data bytes: the 65th word gives no write, `overflow_o` = 1, `word_count_o` stays 64.
4. Embedded markers: FE, 93, FF, FE, 0F, FF.
   - One write of 0x0FFEFF93 at addr 0, then `done_o` = 1.
5. Mid-word reset: FE, AA, BB, then reset for one cycle, then FE, 13, 00, 00, 00.
   - No write during the reset sequence; all outputs zero after reset.
   - The next write is addr 0, data 0x00000013.
6. Reload: after test 1, stream FE, 33, 00, 00, 00.
   - With `INSTR_LOADER_RELOAD_EN`: a write at addr 0 with data 0x00000033, and `done_o` = 0 / `cpu_hold_o` = 1 after the FE edge.
   - Without it: no write, and `done_o` stays 1.
